spi_baud_generator: RTL and testbench
=====================================

// Module: spi_baud_generator
// PURPOSE
//  Generates the SPI serial clock and per-edge strobes for the SPI master.
//  Consumes the mode and clock configuration decoded by the APB slave
//  interface (sppr, spr, cpol, cpha, spi_mode, spiswai) plus ss.
//  Feeds sclk to the pad and the send/receive strobes to the shift register.
// PARAMETERS
//  DIV_W  12  width of baudratedivisor; max divisor is 8*256 = 2048
//  CNT_W  11  width of the half-period counter; max half-period is 1024
// PORTS
//  pclk               in   1      system clock
//  preset_n           in   1      asynchronous active-low reset
//  ss                 in   1      slave select, active low; 0 enables the clock
//  spi_mode           in   2      00 RUN, 01 WAIT, 10/11 STOP
//  spiswai            in   1      1 stops the clock while in WAIT mode
//  cpol               in   1      clock idle level
//  cpha               in   1      0 samples on leading edge; 1 shifts on leading edge
//  sppr               in   3      baud pre-selection
//  spr                in   3      baud selection
//  sclk               out  1      serial clock
//  baudratedivisor    out  DIV_W  (sppr+1) * 2^(spr+1), combinational
//  mosi_send_sclk     out  1      1-pclk strobe on each shift (send) edge
//  miso_receive_sclk  out  1      1-pclk strobe on each sample (receive) edge
// BEHAVIOUR
//  - Reset: sclk=0, count=0, both strobes=0. All state clears asynchronously,
//    including in the middle of a transfer.
//  - HALF = baudratedivisor/2 = (sppr+1) << spr. The range is 1..1024.
//  - active = !ss && (spi_mode==RUN || (spi_mode==WAIT && !spiswai)).
//  - Idle (!active), sampled each pclk:
//    - count<=0, sclk<=cpol, strobes<=0.
//    - sclk always settles at cpol within 1 cycle of deactivation.
//  - Active:
//    - If count >= HALF-1 (terminal), then count<=0 and sclk<=~sclk.
//    - Otherwise count<=count+1.
//    - The >= test makes a divisor reduced mid-count terminate at once, with
//      no wrap to 2^CNT_W.
//    - sclk period = 2*HALF pclk cycles; HALF=1 toggles sclk every pclk.
//  - Edge classification, on a terminal cycle:
//    - The edge is leading if the current sclk==cpol, otherwise trailing.
//    - cpha=0: receive strobe on leading edge, send strobe on trailing edge.
//    - cpha=1: send strobe on leading edge, receive strobe on trailing edge.
//  - Strobe timing: strobes are registered and asserted in the same cycle
//    sclk changes, high for exactly 1 pclk. They are never both high.
//  - Activation: the first toggle occurs HALF cycles after active rises, and
//    the first edge is always leading.
//  - Config changes to cpol/cpha/sppr/spr while active take effect at the next
//    terminal test. Software must change cpol only while idle.
//  - No combinational path from inputs to sclk or the strobes.
// TESTING
//  - Reset/idle: preset_n pulse, ss=1, cpol=1 -> sclk=0 during reset, sclk=1
//    one cycle after release, strobes 0, count 0.
//  - Divisor: sppr=3, spr=2, RUN, ss=0 -> baudratedivisor=32, sclk period
//    32 pclk, 16 high/16 low. sppr=7, spr=7 -> divisor 2048.
//  - Modes 0-3:
//    - cpol=0, cpha=0, sppr=0, spr=0 -> receive strobe on every rise, send on
//      every fall.
//    - cpol=0, cpha=1 -> swapped.
//    - Repeat with cpol=1 -> same roles on the inverted edges.
//  - WAIT/STOP:
//    - WAIT with spiswai=1 mid-transfer -> sclk returns to cpol within 1
//      cycle, count=0.
//    - WAIT with spiswai=0 -> clock keeps running.
//    - spi_mode=10 -> clock held.
//  - Divisor shrink: HALF=16 at count=10, spr changed so HALF=4 -> toggle on
//    the next cycle, then every 4.
//  - Async reset with sclk high and a strobe pending -> all outputs drop
//    immediately, without waiting for pclk.

Source files
------------

// File: rtl/spi_baud_generator_if.sv
// Configuration and clock/strobe bundle between the SPI control logic and the
// baud generator. The generator takes the slave view.
interface spi_baud_generator_if #(
  parameter int DIV_W = 12
);
  logic             ss;
  logic [1:0]       spi_mode;
  logic             spiswai;
  logic             cpol;
  logic             cpha;
  logic [2:0]       sppr;
  logic [2:0]       spr;
  logic             sclk;
  logic [DIV_W-1:0] baudratedivisor;
  logic             mosi_send_sclk;
  logic             miso_receive_sclk;

  modport master (
    output ss, spi_mode, spiswai, cpol, cpha, sppr, spr,
    input  sclk, baudratedivisor, mosi_send_sclk, miso_receive_sclk
  );

  modport slave (
    input  ss, spi_mode, spiswai, cpol, cpha, sppr, spr,
    output sclk, baudratedivisor, mosi_send_sclk, miso_receive_sclk
  );
endinterface

// File: rtl/spi_baud_generator.sv
// SPI serial clock generator: divides pclk by (sppr+1)*2^(spr+1) and emits
// one-pclk send/receive strobes aligned with each sclk edge.
module spi_baud_generator #(
  parameter int DIV_W = 12,
  parameter int CNT_W = 11
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  spi_baud_generator_if.slave  bus
);
  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_WAIT = 2'b01;

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] count_q;
  logic             sclk_q;
  logic             send_q;
  logic             recv_q;
  logic             active;
  logic             terminal;
  logic             leading;

  assign half     = (CNT_W'(bus.sppr) + CNT_W'(1)) << bus.spr;
  assign active   = !bus.ss && ((bus.spi_mode == MODE_RUN) ||
                                ((bus.spi_mode == MODE_WAIT) && !bus.spiswai));
  // >= rather than == so a divisor shrunk below the current count ends the
  // half-period immediately instead of wrapping the counter.
  assign terminal = (count_q >= (half - CNT_W'(1)));
  assign leading  = (sclk_q == bus.cpol);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      count_q <= '0;
      sclk_q  <= 1'b0;
      send_q  <= 1'b0;
      recv_q  <= 1'b0;
    end else if (!active) begin
      count_q <= '0;
      sclk_q  <= bus.cpol;
      send_q  <= 1'b0;
      recv_q  <= 1'b0;
    end else if (terminal) begin
      count_q <= '0;
      sclk_q  <= ~sclk_q;
      // cpha=0 samples on the leading edge; cpha=1 shifts on it.
      recv_q  <= leading ^ bus.cpha;
      send_q  <= ~(leading ^ bus.cpha);
    end else begin
      count_q <= count_q + CNT_W'(1);
      send_q  <= 1'b0;
      recv_q  <= 1'b0;
    end
  end

  assign bus.sclk              = sclk_q;
  assign bus.baudratedivisor   = DIV_W'(half) << 1;
  assign bus.mosi_send_sclk    = send_q;
  assign bus.miso_receive_sclk = recv_q;
endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator: reset, divisor, SPI modes 0-3,
// WAIT/STOP gating, divisor shrink and asynchronous reset.
module tb_spi_baud_generator;
  logic pclk;
  logic preset_n;
  int   n_checks;
  int   n_fail;

  spi_baud_generator_if #(.DIV_W(12)) bus ();

  spi_baud_generator #(.DIV_W(12), .CNT_W(11)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Counts negedges until sclk leaves its current level; returns max_n+1 on timeout.
  task automatic measure(input int max_n, output int n);
    logic v;
    v = bus.sclk;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (bus.sclk == v && n <= max_n);
  endtask

  task automatic setup_idle(input logic cp, input logic ph, input logic [2:0] pp,
                            input logic [2:0] rr, input logic [1:0] md);
    bus.ss       = 1'b1;
    bus.cpol     = cp;
    bus.cpha     = ph;
    bus.sppr     = pp;
    bus.spr      = rr;
    bus.spi_mode = md;
    bus.spiswai  = 1'b0;
    tick(2);
  endtask

  initial begin
    int  n;
    logic lead, exp_recv;
    n_checks = 0;
    n_fail   = 0;

    // Reset and idle level
    bus.ss = 1'b1; bus.spi_mode = 2'b00; bus.spiswai = 1'b0;
    bus.cpol = 1'b1; bus.cpha = 1'b0; bus.sppr = 3'd0; bus.spr = 3'd0;
    preset_n = 1'b1;
    #2 preset_n = 1'b0;
    tick(2);
    check("rst_sclk", 32'(bus.sclk), 0);
    check("rst_send", 32'(bus.mosi_send_sclk), 0);
    check("rst_recv", 32'(bus.miso_receive_sclk), 0);
    check("rst_count", 32'(dut.count_q), 0);
    preset_n = 1'b1;
    tick(1);
    check("idle_sclk_cpol1", 32'(bus.sclk), 1);
    check("idle_count", 32'(dut.count_q), 0);
    check("idle_strobes", 32'({bus.mosi_send_sclk, bus.miso_receive_sclk}), 0);

    // Divisor 32: HALF=16, first toggle after 16, then 16 high / 16 low
    setup_idle(1'b0, 1'b0, 3'd3, 3'd2, 2'b00);
    check("div32", 32'(bus.baudratedivisor), 32);
    check("div32_idle_sclk", 32'(bus.sclk), 0);
    bus.ss = 1'b0;
    measure(40, n);
    check("div32_first", n, 16);
    check("div32_rise_recv", 32'(bus.miso_receive_sclk), 1);
    check("div32_rise_send", 32'(bus.mosi_send_sclk), 0);
    measure(40, n);
    check("div32_high", n, 16);
    check("div32_fall_send", 32'(bus.mosi_send_sclk), 1);
    check("div32_fall_recv", 32'(bus.miso_receive_sclk), 0);
    measure(40, n);
    check("div32_low", n, 16);
    tick(1);
    check("div32_strobe_1cyc", 32'({bus.mosi_send_sclk, bus.miso_receive_sclk}), 0);

    // Maximum divisor 2048: HALF=1024
    setup_idle(1'b0, 1'b0, 3'd7, 3'd7, 2'b00);
    check("div2048", 32'(bus.baudratedivisor), 2048);
    bus.ss = 1'b0;
    measure(1100, n);
    check("div2048_first", n, 1024);

    // SPI modes 0-3 at HALF=1: sclk toggles every pclk
    for (int m = 0; m < 4; m++) begin
      logic cp, ph;
      cp = m[1];
      ph = m[0];
      setup_idle(cp, ph, 3'd0, 3'd0, 2'b00);
      check("div2", 32'(bus.baudratedivisor), 2);
      bus.ss = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        tick(1);
        lead     = (k % 2) == 1;
        exp_recv = ph ? !lead : lead;
        check($sformatf("m%0d_sclk_%0d", m, k), 32'(bus.sclk), 32'(cp ^ lead));
        check($sformatf("m%0d_recv_%0d", m, k), 32'(bus.miso_receive_sclk), 32'(exp_recv));
        check($sformatf("m%0d_send_%0d", m, k), 32'(bus.mosi_send_sclk), 32'(!exp_recv));
      end
    end

    // WAIT with spiswai=0 keeps running; spiswai=1 parks sclk at cpol
    setup_idle(1'b0, 1'b0, 3'd3, 3'd0, 2'b01);
    bus.ss = 1'b0;
    measure(20, n);
    check("wait_run_first", n, 4);
    measure(20, n);
    check("wait_run_high", n, 4);
    measure(20, n);
    check("wait_run_low", n, 4);
    tick(2);
    check("wait_mid_sclk", 32'(bus.sclk), 1);
    check("wait_mid_count", 32'(dut.count_q), 2);
    bus.spiswai = 1'b1;
    tick(1);
    check("wait_stop_sclk", 32'(bus.sclk), 0);
    check("wait_stop_count", 32'(dut.count_q), 0);
    bus.spiswai = 1'b0;
    bus.spi_mode = 2'b10;
    tick(6);
    check("stop10_sclk", 32'(bus.sclk), 0);
    check("stop10_count", 32'(dut.count_q), 0);
    bus.spi_mode = 2'b11;
    tick(6);
    check("stop11_sclk", 32'(bus.sclk), 0);
    check("stop11_strobes", 32'({bus.mosi_send_sclk, bus.miso_receive_sclk}), 0);

    // Divisor shrink mid-count: HALF 16 -> 4 at count 10
    setup_idle(1'b0, 1'b0, 3'd3, 3'd2, 2'b00);
    bus.ss = 1'b0;
    tick(10);
    check("shrink_count10", 32'(dut.count_q), 10);
    check("shrink_pre_sclk", 32'(bus.sclk), 0);
    bus.spr = 3'd0;
    tick(1);
    check("shrink_sclk", 32'(bus.sclk), 1);
    check("shrink_count0", 32'(dut.count_q), 0);
    check("shrink_recv", 32'(bus.miso_receive_sclk), 1);
    measure(20, n);
    check("shrink_next", n, 4);

    // Asynchronous reset with sclk high and a strobe asserted
    setup_idle(1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
    bus.ss = 1'b0;
    tick(1);
    check("arst_pre_sclk", 32'(bus.sclk), 1);
    check("arst_pre_recv", 32'(bus.miso_receive_sclk), 1);
    #2 preset_n = 1'b0;
    #1;
    check("arst_sclk", 32'(bus.sclk), 0);
    check("arst_recv", 32'(bus.miso_receive_sclk), 0);
    check("arst_send", 32'(bus.mosi_send_sclk), 0);
    check("arst_count", 32'(dut.count_q), 0);
    @(negedge pclk);
    preset_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
